// File: rtl/bn_act_stream.sv
// Streaming fixed-point batch-norm (y = a*x + b, rounded shift) plus activation, LANES channels per beat.
// Ports: clk/rst (sync active-high); cfg_* writes per-channel a/b; mode_i/cap_val_i select activation;
//        in_* / out_* are valid-ready streams. Latency 4 cycles after the accept edge; global stall when out is blocked.
module bn_act_stream #(
    parameter int LANES   = 2,
    parameter int NO_CH   = 8,
    parameter int BW_IN   = 12,
    parameter int BW_A    = 12,
    parameter int BW_B    = 16,
    parameter int BW_OUT  = 12,
    parameter int R_SHIFT = 6,
    parameter int ROUND   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we_i,
    input  logic [$clog2(NO_CH)-1:0]    cfg_addr_i,
    input  logic signed [BW_A-1:0]      cfg_a_i,
    input  logic signed [BW_B-1:0]      cfg_b_i,
    input  logic [1:0]                  mode_i,
    input  logic signed [BW_OUT-1:0]    cap_val_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES*BW_IN-1:0]      in_data_i,
    input  logic                        in_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*BW_OUT-1:0]     out_data_o,
    output logic                        out_last_o
);

    localparam int AW = $clog2(NO_CH);
    localparam int G  = NO_CH / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int MW = BW_A + BW_IN;   // product width
    localparam int SW = MW + 1;         // product + bias
    localparam int HW = SW + 1;         // guard bit for the rounding add
    localparam logic signed [HW-1:0] PMAX = HW'((2 ** (BW_OUT - 1)) - 1);
    localparam logic signed [HW-1:0] NMIN = HW'(-(2 ** (BW_OUT - 1)));
    localparam logic signed [HW-1:0] RND  = (ROUND != 0) ? HW'(2 ** (R_SHIFT - 1)) : '0;

    // Coefficient register file
    logic signed [BW_A-1:0] a_q [NO_CH];
    logic signed [BW_B-1:0] b_q [NO_CH];
    logic                   addr_ok;

    // Group counter
    logic [GW-1:0] g_q, g_d;

    // Stage 0: accepted beat with its coefficients and controls
    logic                     v0_q, l0_q;
    logic signed [BW_IN-1:0]  x0_q [LANES];
    logic signed [BW_A-1:0]   a0_q [LANES];
    logic signed [BW_B-1:0]   b0_q [LANES], b0_d [LANES];
    logic signed [BW_A-1:0]   a0_d [LANES];
    logic signed [BW_IN-1:0]  x0_d [LANES];
    logic [1:0]               m0_q;
    logic signed [BW_OUT-1:0] c0_q;
    logic [AW-1:0]            ch_idx [LANES];

    // Stage 1: product
    logic                     v1_q, l1_q;
    logic signed [MW-1:0]     p1_q [LANES], p1_d [LANES];
    logic signed [BW_B-1:0]   b1_q [LANES];
    logic [1:0]               m1_q;
    logic signed [BW_OUT-1:0] c1_q;

    // Stage 2: biased sum
    logic                     v2_q, l2_q;
    logic signed [SW-1:0]     s2_q [LANES], s2_d [LANES];
    logic [1:0]               m2_q;
    logic signed [BW_OUT-1:0] c2_q;

    // Stage 3: rounded, shifted value
    logic                     v3_q, l3_q;
    logic signed [HW-1:0]     h3_q [LANES], h3_d [LANES];
    logic signed [HW-1:0]     rnd  [LANES];
    logic [1:0]               m3_q;
    logic signed [BW_OUT-1:0] c3_q;

    // Stage 4: output register
    logic                      out_valid_q, out_last_q;
    logic [LANES*BW_OUT-1:0]   out_data_q, out_data_d;

    logic en, accept;

    // Whole pipeline advances together; a blocked output freezes every stage, bubbles included.
    assign en         = out_ready_i | ~out_valid_q;
    assign accept     = in_valid_i & en;
    assign in_ready_o = en;
    assign addr_ok    = (32'(cfg_addr_i) < NO_CH);

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

    function automatic logic signed [BW_OUT-1:0] activate(
        input logic signed [HW-1:0]     sh,
        input logic [1:0]               mode,
        input logic signed [BW_OUT-1:0] cap
    );
        logic signed [HW-1:0] r;
        logic signed [HW-1:0] capx;
        capx = HW'(cap);
        if (mode[1]) begin
            if (sh > PMAX)      r = PMAX;
            else if (sh < NMIN) r = NMIN;
            else                r = sh;
        end else begin
            if (sh[HW-1])       r = '0;
            else if (sh > PMAX) r = PMAX;
            else                r = sh;
            // A negative cap disables the clamp, leaving plain ReLU.
            if (mode[0] && !cap[BW_OUT-1] && (r > capx)) r = capx;
        end
        return BW_OUT'(r);
    endfunction

    always_comb begin
        if (in_last_i)                g_d = '0;
        else if (32'(g_q) == G - 1)   g_d = '0;
        else                          g_d = g_q + 1'b1;

        out_data_d = '0;
        for (int l = 0; l < LANES; l++) begin
            ch_idx[l] = AW'(int'(g_q) * LANES + l);
            x0_d[l]   = in_data_i[l*BW_IN +: BW_IN];
            a0_d[l]   = a_q[ch_idx[l]];
            b0_d[l]   = b_q[ch_idx[l]];
            p1_d[l]   = MW'(a0_q[l]) * MW'(x0_q[l]);
            s2_d[l]   = SW'(p1_q[l]) + SW'(b1_q[l]);
            rnd[l]    = HW'(s2_q[l]) + RND;
            h3_d[l]   = rnd[l] >>> R_SHIFT;
            out_data_d[l*BW_OUT +: BW_OUT] = activate(h3_q[l], m3_q, c3_q);
        end
    end

    // Coefficient file and group counter are independent of the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q <= '0;
            for (int c = 0; c < NO_CH; c++) begin
                a_q[c] <= '0;
                b_q[c] <= '0;
            end
        end else begin
            if (accept) g_q <= g_d;
            if (cfg_we_i && addr_ok) begin
                a_q[cfg_addr_i] <= cfg_a_i;
                b_q[cfg_addr_i] <= cfg_b_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0; l0_q <= 1'b0; m0_q <= '0; c0_q <= '0;
            v1_q <= 1'b0; l1_q <= 1'b0; m1_q <= '0; c1_q <= '0;
            v2_q <= 1'b0; l2_q <= 1'b0; m2_q <= '0; c2_q <= '0;
            v3_q <= 1'b0; l3_q <= 1'b0; m3_q <= '0; c3_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int l = 0; l < LANES; l++) begin
                x0_q[l] <= '0; a0_q[l] <= '0; b0_q[l] <= '0;
                p1_q[l] <= '0; b1_q[l] <= '0;
                s2_q[l] <= '0;
                h3_q[l] <= '0;
            end
        end else if (en) begin
            v0_q <= in_valid_i; l0_q <= in_last_i; m0_q <= mode_i; c0_q <= cap_val_i;
            v1_q <= v0_q;       l1_q <= l0_q;      m1_q <= m0_q;   c1_q <= c0_q;
            v2_q <= v1_q;       l2_q <= l1_q;      m2_q <= m1_q;   c2_q <= c1_q;
            v3_q <= v2_q;       l3_q <= l2_q;      m3_q <= m2_q;   c3_q <= c2_q;
            out_valid_q <= v3_q;
            out_last_q  <= l3_q;
            out_data_q  <= out_data_d;
            for (int l = 0; l < LANES; l++) begin
                x0_q[l] <= x0_d[l]; a0_q[l] <= a0_d[l]; b0_q[l] <= b0_d[l];
                p1_q[l] <= p1_d[l]; b1_q[l] <= b0_q[l];
                s2_q[l] <= s2_d[l];
                h3_q[l] <= h3_d[l];
            end
        end
    end

endmodule

// File: doc/bn_act_stream.md
Name: bn_act_stream

Overview:
- Streaming fixed-point batch-norm plus activation stage for the CNN datapath; successor to the fixed-channel BN/ReLU block.
- Processes LANES channels per beat, time-multiplexed over NO_CH channels, with per-channel coefficients held in a runtime-writable register file.
- Adds valid/ready backpressure, optional rounding, runtime activation mode and cap, and symmetric output saturation.
- Sits between a conv accumulator and the next layer's input buffer.

Parameters:
- LANES, 2: channels processed per beat.
- NO_CH, 8: total channels; must be a multiple of LANES. NO_CH/LANES = number of channel groups G.
- BW_IN, 12: signed input width.
- BW_A, 12: signed scale coefficient width.
- BW_B, 16: signed bias width, LSB-aligned to the product.
- BW_OUT, 12: signed output width.
- R_SHIFT, 6: arithmetic right shift after bias add; must be >= 1.
- ROUND, 1: 1 = add 2^(R_SHIFT-1) before the shift (round half up); 0 = truncate.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- cfg_we, input, 1: coefficient write strobe.
- cfg_addr, input, clog2(NO_CH): channel index to write.
- cfg_a, input, BW_A: scale value written.
- cfg_b, input, BW_B: bias value written.
- mode, input, 2: activation mode. 00 ReLU, 01 ReLU with cap, 10/11 linear.
- cap_val, input, BW_OUT: upper clamp used in mode 01.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block accepts a beat this cycle.
- in_data, input, LANES x BW_IN: lane l carries channel g*LANES+l.
- in_last, input, 1: last beat of a frame.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, LANES x BW_OUT: results.
- out_last, output, 1: in_last delayed with its beat.

Behaviour:
- Reset:
  - out_valid, out_last and out_data = 0.
  - Group counter g = 0.
  - All coefficients a = 0, b = 0.
  - Every in-flight beat is discarded; reset mid-stream produces no partial output afterwards.
- Pipeline: 4 stages with global enable en = out_ready | !out_valid.
  - in_ready = en.
  - A beat is accepted when in_valid & in_ready.
  - When en = 0, every stage holds its contents; bubbles are not collapsed.
- Latency: accepted at edge N, the result is visible on out_valid/out_data after edge N+4 when no stall occurs. Throughput is 1 beat/cycle.
- Acceptance:
  - a[ch] and b[ch] are read for each lane, and mode and cap_val are sampled.
  - b, mode, cap_val and in_last travel with the beat.
  - Later changes never affect a beat already accepted.
- Stage 1: mult = signed a * signed x, width BW_A+BW_IN.
- Stage 2: sum = mult + sign-extended b, width BW_A+BW_IN+1. b is sign-extended or truncated to that width if wider.
- Stage 3: sh = (sum + (ROUND ? 2^(R_SHIFT-1) : 0)) >>> R_SHIFT. The adder carries one extra guard bit so no overflow occurs.
- Stage 4: let PMAX = 2^(BW_OUT-1)-1 and NMIN = -2^(BW_OUT-1).
  - Mode 00: sh < 0 gives 0; sh > PMAX gives PMAX; otherwise sh.
  - Mode 01: as mode 00, then the result is clamped to cap_val when cap_val >= 0 and the result > cap_val. A negative cap_val behaves as mode 00.
  - Mode 1x: sh saturated to the range [NMIN, PMAX].
- Group counter g:
  - Increments on each accepted beat and wraps from G-1 to 0.
  - An accepted beat with in_last = 1 forces g = 0 next cycle, regardless of value.
- Coefficient writes:
  - cfg_we writes a[cfg_addr] and b[cfg_addr] at the edge.
  - A beat accepted in the same cycle as a write to its channel uses the old values.
  - cfg_addr >= NO_CH: write ignored.
  - Writes are allowed during stalls and do not stall the pipeline.
- out_data and out_last are held stable while out_valid & !out_ready.

Test Plan:
- Defaults, ROUND=1, mode 00, a[0]=64, b[0]=0, beat x0=100 -> out_data[0]=100 exactly 4 cycles after acceptance; out_valid high for one cycle.
- Rounding, a[0]=1, b[0]=0, x0=32 -> out 1 with ROUND=1; out 0 with ROUND=0 build. With x0=31 -> 0 in both builds.
- Negative and linear, a[0]=64, b[0]=-6400, x0=50 -> mode 00 gives 0; mode 10 gives -50. With x0=-2048, b=0 in mode 10 -> -2048.
- Saturation and cap, a[0]=2047, b[0]=0, x0=2047 (sh=65472) -> mode 10 gives 2047; mode 01 with cap_val=1000 gives 1000; mode 00 gives 2047.
- Backpressure, stream 8 consecutive beats, out_ready=0 for 3 cycles mid-stream -> in_ready low during the stall; all 8 results in order with no duplicates; out_data stable while stalled.
- Grouping, reset and write ordering:
  - Beats with in_last on the 2nd beat -> the 3rd beat uses coefficients of channels 0,1.
  - rst asserted with 3 beats in flight -> no out_valid afterwards until new input.
  - A write to ch0 in the same cycle as a ch0 beat -> that beat uses the old coefficients.
